// File: rtl/gig_eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gig_eth_pkg
//  Description : Shared types and constants for the gig_eth TX arbiter.
//                Holds the arbiter state encoding, the frame length counter
//                width and the default standard/jumbo frame byte limits.
//  Revision    : 1.0  initial release
// ============================================================================
package gig_eth_pkg;

  // Frame length counter width; wide enough for the jumbo limit.
  localparam int LEN_W = 14;

  // Default byte limits for standard and jumbo frames.
  localparam int MAX_FRAME_SIZE_STANDARD_DEF = 1522;
  localparam int MAX_FRAME_SIZE_JUMBO_DEF    = 9022;

  // Arbiter frame-level states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_ACK = 3'd1,
    ST_XFER     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_GAP      = 3'd4
  } tx_state_e;

  // Saturating increment so a runaway source can never wrap the counter.
  function automatic logic [LEN_W-1:0] len_inc_sat(input logic [LEN_W-1:0] len);
    return (len == {LEN_W{1'b1}}) ? len : len + 1'b1;
  endfunction

endpackage : gig_eth_pkg
`default_nettype wire

// File: rtl/gig_eth_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gig_eth_rr_arbiter
//  Description : Combinational round-robin owner select. Returns the first
//                requester found after rr_ptr_i, searching upward and
//                wrapping at NUM_SRC. The pointer position itself is checked
//                last so the previous owner has lowest priority.
//  Revision    : 1.0  initial release
// ============================================================================
module gig_eth_rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req_i,
  input  logic [$clog2(NUM_SRC)-1:0] rr_ptr_i,
  output logic                       gnt_vld_o,
  output logic [$clog2(NUM_SRC)-1:0] gnt_idx_o
);

  localparam int c_IDX_W = $clog2(NUM_SRC);

  // Index that sits 'off' positions after the pointer, modulo NUM_SRC.
  function automatic logic [c_IDX_W-1:0] wrap_idx(input logic [c_IDX_W-1:0] base,
                                                  input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) begin
      s = s - NUM_SRC;
    end
    return c_IDX_W'(s);
  endfunction

  // Scan from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (req_i[wrap_idx(rr_ptr_i, k)]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = wrap_idx(rr_ptr_i, k);
      end
    end
  end

endmodule : gig_eth_rr_arbiter
`default_nettype wire

// File: rtl/gig_eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gig_eth_tx_arbiter
//  Description : Frame-level round-robin arbiter sharing one gig_eth_mac TX
//                client port among NUM_SRC frame sources. Grants one source
//                per frame, muxes its bytes to the MAC, truncates frames at
//                the standard/jumbo byte limit and forces an idle gap of
//                IFG_CYCLES cycles after every frame.
//  Revision    : 1.0  initial release
// ============================================================================
module gig_eth_tx_arbiter
  import gig_eth_pkg::*;
#(
  parameter int NUM_SRC                 = 4,
  parameter int MAX_FRAME_SIZE_STANDARD = MAX_FRAME_SIZE_STANDARD_DEF,
  parameter int MAX_FRAME_SIZE_JUMBO    = MAX_FRAME_SIZE_JUMBO_DEF,
  parameter int IFG_CYCLES              = 2
) (
  input  logic                       tx_clk,
  input  logic                       reset,
  input  logic                       conf_tx_en,
  input  logic                       conf_tx_jumbo_en,
  input  logic [NUM_SRC*8-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_dvld,
  input  logic [NUM_SRC-1:0]         src_underrun,
  output logic [NUM_SRC-1:0]         src_rd,
  output logic [7:0]                 mac_tx_data,
  output logic                       mac_tx_dvld,
  output logic                       mac_tx_underrun,
  input  logic                       mac_tx_ack,
  output logic                       grant_valid,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic                       frame_done,
  output logic                       oversize_err
);

  localparam int                 c_IDX_W       = $clog2(NUM_SRC);
  localparam int                 c_GAP_W       = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LAST    = c_GAP_W'(IFG_CYCLES - 1);
  localparam logic [LEN_W-1:0]   c_LIMIT_STD   = LEN_W'(MAX_FRAME_SIZE_STANDARD);
  localparam logic [LEN_W-1:0]   c_LIMIT_JUMBO = LEN_W'(MAX_FRAME_SIZE_JUMBO);

  tx_state_e            state_q,  state_d;
  logic [c_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [c_IDX_W-1:0]   grant_q,  grant_d;
  logic [LEN_W-1:0]     limit_q,  limit_d;
  logic [LEN_W-1:0]     len_q,    len_d;
  logic [c_GAP_W-1:0]   gap_q,    gap_d;

  logic                 w_arb_vld;
  logic [c_IDX_W-1:0]   w_arb_idx;
  logic [7:0]           w_sel_data;
  logic                 w_sel_dvld;
  logic                 w_sel_und;
  logic                 w_rd_en;

  gig_eth_rr_arbiter #(
    .NUM_SRC   (NUM_SRC)
  ) u_rr_arbiter (
    .req_i     (src_dvld),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_vld_o (w_arb_vld),
    .gnt_idx_o (w_arb_idx)
  );

  // Pick out the byte, valid and underrun of the currently granted source.
  always_comb begin
    w_sel_data = '0;
    w_sel_dvld = 1'b0;
    w_sel_und  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == c_IDX_W'(i)) begin
        w_sel_data = src_data[i*8 +: 8];
        w_sel_dvld = src_dvld[i];
        w_sel_und  = src_underrun[i];
      end
    end
  end

  // Next-state logic and per-cycle MAC-side strobes.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_d         = grant_q;
    limit_d         = limit_q;
    len_d           = len_q;
    gap_d           = gap_q;
    w_rd_en         = 1'b0;
    mac_tx_dvld     = 1'b0;
    mac_tx_underrun = 1'b0;
    frame_done      = 1'b0;
    oversize_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (conf_tx_en && w_arb_vld) begin
          grant_d  = w_arb_idx;
          rr_ptr_d = w_arb_idx;
          limit_d  = conf_tx_jumbo_en ? c_LIMIT_JUMBO : c_LIMIT_STD;
          len_d    = '0;
          state_d  = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        mac_tx_dvld = w_sel_dvld;
        if (!w_sel_dvld) begin
          // Source withdrew before the MAC started: silently give up the slot.
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (mac_tx_ack) begin
          w_rd_en = 1'b1;
          len_d   = LEN_W'(1);
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        mac_tx_dvld = w_sel_dvld;
        w_rd_en     = w_sel_dvld;
        if (!w_sel_dvld) begin
          frame_done = 1'b1;
          gap_d      = '0;
          state_d    = ST_GAP;
        end else begin
          len_d = len_inc_sat(len_q);
          // Source abort and length overflow share one MAC abort; the byte
          // presented alongside it is consumed and discarded by the MAC.
          if (w_sel_und || (len_q == limit_q)) begin
            mac_tx_underrun = 1'b1;
            oversize_err    = (len_q == limit_q);
            state_d         = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Keep reading the aborted frame so the source reaches its end.
        w_rd_en = w_sel_dvld;
        if (!w_sel_dvld) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == c_GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Route the read strobe only to the owning source.
  always_comb begin
    src_rd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_rd[i] = w_rd_en && (grant_q == c_IDX_W'(i));
    end
  end

  // Ownership is visible while a frame (or its drain) is in progress.
  always_comb begin
    grant_valid = (state_q == ST_WAIT_ACK) || (state_q == ST_XFER) || (state_q == ST_DRAIN);
    grant_idx   = grant_q;
    mac_tx_data = grant_valid ? w_sel_data : 8'h00;
  end

  // State, pointer and counter registers.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= c_IDX_W'(NUM_SRC - 1);
      grant_q  <= '0;
      limit_q  <= c_LIMIT_STD;
      len_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      limit_q  <= limit_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
    end
  end

endmodule : gig_eth_tx_arbiter
`default_nettype wire

// File: tb/tb_gig_eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gig_eth_tx_arbiter
//  Description : Self-checking bench for gig_eth_tx_arbiter. Sources present
//                a known byte pattern and advance on src_rd; a small MAC
//                model acks the second cycle of each new frame.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gig_eth_tx_arbiter;

  logic        tx_clk;
  logic        reset;
  logic        conf_tx_en;
  logic        conf_tx_jumbo_en;
  logic [31:0] src_data;
  logic [3:0]  src_dvld;
  logic [3:0]  src_underrun;
  logic [3:0]  src_rd;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_dvld;
  logic        mac_tx_underrun;
  logic        mac_tx_ack;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic        frame_done;
  logic        oversize_err;

  gig_eth_tx_arbiter #(
    .NUM_SRC                 (4),
    .MAX_FRAME_SIZE_STANDARD (1522),
    .MAX_FRAME_SIZE_JUMBO    (9022),
    .IFG_CYCLES              (2)
  ) dut (
    .tx_clk           (tx_clk),
    .reset            (reset),
    .conf_tx_en       (conf_tx_en),
    .conf_tx_jumbo_en (conf_tx_jumbo_en),
    .src_data         (src_data),
    .src_dvld         (src_dvld),
    .src_underrun     (src_underrun),
    .src_rd           (src_rd),
    .mac_tx_data      (mac_tx_data),
    .mac_tx_dvld      (mac_tx_dvld),
    .mac_tx_underrun  (mac_tx_underrun),
    .mac_tx_ack       (mac_tx_ack),
    .grant_valid      (grant_valid),
    .grant_idx        (grant_idx),
    .frame_done       (frame_done),
    .oversize_err     (oversize_err)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  int checks   = 0;
  int failures = 0;

  // Source and MAC models
  int remain [4];
  int sent   [4];
  int und_at [4];
  int reload_len [4];
  bit auto_reload [4];
  bit mac_busy;
  int pend;

  // Observed statistics
  int rd_cnt [4];
  int done_cnt, ovr_cnt, und_cnt, data_err, onehot_err, mac_dvld_cnt;
  bit ev_seen;
  int rd_before_ev, rd_from_ev, dvld_after_ev;
  int grant_log [$];
  int gap_log [$];
  int gv_low_run;
  bit prev_gv, had_frame, s_gv;
  int cyc, first_grant_cyc;

  function automatic logic [7:0] byte_of(input int src, input int n);
    return 8'((src * 37 + n * 3 + 1) & 255);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      remain[i] = 0; sent[i] = 0; und_at[i] = -1; reload_len[i] = 0; auto_reload[i] = 1'b0;
    end
    mac_busy = 1'b0;
    pend     = 0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) rd_cnt[i] = 0;
    done_cnt = 0; ovr_cnt = 0; und_cnt = 0; data_err = 0; onehot_err = 0; mac_dvld_cnt = 0;
    ev_seen = 1'b0; rd_before_ev = 0; rd_from_ev = 0; dvld_after_ev = 0;
    grant_log.delete(); gap_log.delete();
    gv_low_run = 0; prev_gv = 1'b0; had_frame = 1'b0; s_gv = 1'b0;
    cyc = 0; first_grant_cyc = -1;
  endtask

  // One clock: drive from the models, sample at negedge, then advance models.
  task automatic cycle();
    for (int i = 0; i < 4; i++) begin
      src_dvld[i]        = (remain[i] > 0);
      src_data[i*8 +: 8] = byte_of(i, sent[i]);
      src_underrun[i]    = (remain[i] > 0) && (sent[i] == und_at[i]);
    end
    mac_tx_ack = !mac_busy && (pend >= 1);
    @(negedge tx_clk);
    s_gv = grant_valid;
    if (src_rd !== 4'b0000) begin
      if (!grant_valid || (src_rd !== (4'b0001 << grant_idx))) onehot_err++;
    end
    if (mac_tx_dvld) begin
      mac_dvld_cnt++;
      if (mac_tx_data !== byte_of(int'(grant_idx), sent[grant_idx])) data_err++;
    end
    if (mac_tx_underrun) und_cnt++;
    if (oversize_err)    ovr_cnt++;
    if (frame_done)      done_cnt++;
    for (int i = 0; i < 4; i++) rd_cnt[i] += int'(src_rd[i]);
    if (mac_tx_underrun) ev_seen = 1'b1;
    if (ev_seen) begin
      rd_from_ev += int'(|src_rd);
      if (mac_tx_dvld && !mac_tx_underrun) dvld_after_ev++;
    end else begin
      rd_before_ev += int'(|src_rd);
    end
    if (grant_valid && !prev_gv) begin
      grant_log.push_back(int'(grant_idx));
      if (had_frame) gap_log.push_back(gv_low_run);
      if (first_grant_cyc < 0) first_grant_cyc = cyc;
      had_frame = 1'b1;
    end
    if (!grant_valid) gv_low_run++; else gv_low_run = 0;
    prev_gv = grant_valid;
    for (int i = 0; i < 4; i++) begin
      if (!src_dvld[i] && auto_reload[i]) begin
        remain[i] = reload_len[i]; sent[i] = 0;
      end else if (src_rd[i]) begin
        sent[i]++; remain[i]--;
      end
    end
    if (mac_tx_dvld) begin
      if (!mac_busy) begin
        if (mac_tx_ack) begin mac_busy = 1'b1; pend = 0; end
        else pend++;
      end
    end else begin
      mac_busy = 1'b0; pend = 0;
    end
    cyc++;
    @(posedge tx_clk); #1;
  endtask

  // Run until the DUT is idle with no pending sources for a few cycles.
  task automatic run_quiet(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok    = 1'b0;
    for (int n = 0; n < budget; n++) begin
      cycle();
      if (!s_gv && (src_dvld == 4'b0000)) quiet++; else quiet = 0;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    src_dvld = '0; src_underrun = '0; src_data = '0; mac_tx_ack = 1'b0;
    model_clear();
    repeat (2) @(posedge tx_clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; conf_tx_en = 1'b1; conf_tx_jumbo_en = 1'b0;
    src_dvld = 4'hF; src_underrun = 4'hF; src_data = 32'hA5A5_A5A5; mac_tx_ack = 1'b1;
    #12;
    checks++;
    if ({src_rd, mac_tx_data, mac_tx_dvld, mac_tx_underrun, grant_valid, frame_done, oversize_err} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got rd=%b data=%h dvld=%b und=%b gv=%b done=%b ovr=%b expected all 0",
               src_rd, mac_tx_data, mac_tx_dvld, mac_tx_underrun, grant_valid, frame_done, oversize_err);
    end
    checks++;
    if (grant_idx !== 2'd0) begin
      failures++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx);
    end
    apply_reset();
    clear_stats();
    repeat (3) cycle();
    checks++;
    if (grant_log.size() !== 0) begin
      failures++; $display("FAIL idle_no_grant: got %0d grants expected 0", grant_log.size());
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    clear_stats();
    remain[0] = 64;
    run_quiet(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: got stuck expected idle"); end
    checks++;
    if (first_grant_cyc !== 1) begin
      failures++; $display("FAIL single_grant_latency: got %0d expected 1", first_grant_cyc);
    end
    checks++;
    if (rd_cnt[0] !== 64) begin failures++; $display("FAIL single_rd_count: got %0d expected 64", rd_cnt[0]); end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL single_frame_done: got %0d expected 1", done_cnt); end
    // One WAIT_ACK cycle before the ack plus 64 bytes.
    checks++;
    if (mac_dvld_cnt !== 65) begin failures++; $display("FAIL single_dvld_cycles: got %0d expected 65", mac_dvld_cnt); end
    checks++;
    if ((data_err !== 0) || (onehot_err !== 0)) begin
      failures++; $display("FAIL single_data: got data_err=%0d rd_err=%0d expected 0/0", data_err, onehot_err);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int expg [5];
    expg = '{0, 1, 2, 3, 0};
    apply_reset();
    clear_stats();
    for (int i = 0; i < 4; i++) begin
      remain[i] = 8; reload_len[i] = 8; auto_reload[i] = 1'b1;
    end
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (grant_log.size() >= 5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL rr_timeout: got %0d grants expected 5", grant_log.size()); end
    for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
      checks++;
      if (grant_log[k] !== expg[k]) begin
        failures++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, grant_log[k], expg[k]);
      end
    end
    // IFG_CYCLES gap cycles plus the one-cycle grant in IDLE.
    for (int k = 0; k < gap_log.size(); k++) begin
      checks++;
      if (gap_log[k] !== 3) begin
        failures++; $display("FAIL rr_gap[%0d]: got %0d expected 3", k, gap_log[k]);
      end
    end
    checks++;
    if (done_cnt !== 4) begin failures++; $display("FAIL rr_done: got %0d expected 4", done_cnt); end
    for (int i = 0; i < 4; i++) auto_reload[i] = 1'b0;
    run_quiet(600, ok);
    checks++;
    if (!ok || (data_err !== 0) || (onehot_err !== 0)) begin
      failures++; $display("FAIL rr_drain: got ok=%0d data_err=%0d rd_err=%0d expected 1/0/0", ok, data_err, onehot_err);
    end
  endtask

  task automatic test_oversize();
    bit ok;
    conf_tx_jumbo_en = 1'b0;
    clear_stats();
    remain[1] = 1522;
    run_quiet(1700, ok);
    checks++;
    if (!ok || (done_cnt !== 1) || (ovr_cnt !== 0) || (und_cnt !== 0) || (rd_cnt[1] !== 1522)) begin
      failures++;
      $display("FAIL std_exact_limit: got ok=%0d done=%0d ovr=%0d und=%0d rd=%0d expected 1/1/0/0/1522",
               ok, done_cnt, ovr_cnt, und_cnt, rd_cnt[1]);
    end
    clear_stats();
    remain[1] = 1600; sent[1] = 0;
    run_quiet(1800, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ovr_timeout: got stuck expected idle"); end
    checks++;
    if ((ovr_cnt !== 1) || (und_cnt !== 1) || (done_cnt !== 0)) begin
      failures++; $display("FAIL ovr_pulses: got ovr=%0d und=%0d done=%0d expected 1/1/0", ovr_cnt, und_cnt, done_cnt);
    end
    checks++;
    if (rd_before_ev !== 1522) begin failures++; $display("FAIL ovr_bytes_before: got %0d expected 1522", rd_before_ev); end
    checks++;
    if (rd_from_ev !== 78) begin failures++; $display("FAIL ovr_bytes_drained: got %0d expected 78", rd_from_ev); end
    checks++;
    if ((dvld_after_ev !== 0) || (rd_cnt[1] !== 1600)) begin
      failures++; $display("FAIL ovr_drain: got dvld_after=%0d rd=%0d expected 0/1600", dvld_after_ev, rd_cnt[1]);
    end
  endtask

  task automatic test_jumbo_underrun();
    bit ok;
    conf_tx_jumbo_en = 1'b1;
    clear_stats();
    remain[2] = 9000; sent[2] = 0;
    repeat (10) cycle();
    conf_tx_jumbo_en = 1'b0;  // limit was latched at grant
    run_quiet(9200, ok);
    checks++;
    if (!ok || (done_cnt !== 1) || (ovr_cnt !== 0) || (und_cnt !== 0) || (rd_cnt[2] !== 9000)) begin
      failures++;
      $display("FAIL jumbo_9000: got ok=%0d done=%0d ovr=%0d und=%0d rd=%0d expected 1/1/0/0/9000",
               ok, done_cnt, ovr_cnt, und_cnt, rd_cnt[2]);
    end
    clear_stats();
    remain[3] = 200; sent[3] = 0; und_at[3] = 100;
    run_quiet(400, ok);
    checks++;
    if (!ok || (und_cnt !== 1) || (ovr_cnt !== 0) || (done_cnt !== 0)) begin
      failures++; $display("FAIL underrun_pulses: got ok=%0d und=%0d ovr=%0d done=%0d expected 1/1/0/0", ok, und_cnt, ovr_cnt, done_cnt);
    end
    checks++;
    if ((rd_before_ev !== 100) || (rd_cnt[3] !== 200) || (dvld_after_ev !== 0)) begin
      failures++; $display("FAIL underrun_drain: got before=%0d rd=%0d dvld_after=%0d expected 100/200/0",
                           rd_before_ev, rd_cnt[3], dvld_after_ev);
    end
    und_at[3] = -1;
  endtask

  task automatic test_disable_and_reset();
    bit ok;
    clear_stats();
    conf_tx_en = 1'b1;
    remain[0] = 50; sent[0] = 0;
    repeat (3) cycle();
    conf_tx_en = 1'b0;
    remain[1] = 20; sent[1] = 0;
    repeat (100) cycle();
    checks++;
    if ((done_cnt !== 1) || (rd_cnt[0] !== 50)) begin
      failures++; $display("FAIL disable_finish: got done=%0d rd=%0d expected 1/50", done_cnt, rd_cnt[0]);
    end
    checks++;
    if ((grant_log.size() !== 1) || (rd_cnt[1] !== 0) || (s_gv !== 1'b0)) begin
      failures++; $display("FAIL disable_no_grant: got grants=%0d rd1=%0d gv=%0d expected 1/0/0", grant_log.size(), rd_cnt[1], s_gv);
    end
    conf_tx_en = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (rd_cnt[1] >= 5) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || (grant_idx !== 2'd1)) begin
      failures++; $display("FAIL reenable_grant: got ok=%0d idx=%0d expected 1/1", ok, grant_idx);
    end
    reset = 1'b1;
    #2;
    checks++;
    if ({src_rd, mac_tx_data, mac_tx_dvld, mac_tx_underrun, grant_valid, grant_idx, frame_done, oversize_err} !== 19'd0) begin
      failures++;
      $display("FAIL midframe_reset: got rd=%b data=%h dvld=%b und=%b gv=%b idx=%0d expected all 0",
               src_rd, mac_tx_data, mac_tx_dvld, mac_tx_underrun, grant_valid, grant_idx);
    end
    @(posedge tx_clk); #1;
    reset = 1'b0;
    model_clear();
    repeat (3) cycle();
  endtask

  initial begin
    model_clear();
    clear_stats();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_oversize();
    test_jumbo_underrun();
    test_disable_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_gig_eth_tx_arbiter
`default_nettype wire
